// File: rtl/wm8960_pkg.sv
// WM8960 register sequencer: shared constants, state encoding and table entry.
package wm8960_pkg;

  localparam logic [7:0]  DEV_ADDR  = 8'h34;
  localparam logic [6:0]  RESET_REG = 7'h0F;
  localparam logic [15:0] END_MARK  = 16'hFFFF;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    LATCH,
    ISSUE,
    WAIT,
    GAP,
    RUN,
    U_ISSUE,
    U_WAIT,
    ERR
  } state_t;

  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] data;
  } entry_t;

  function automatic logic [7:0] b1_of(entry_t e);
    return {e.addr, e.data[8]};
  endfunction

  function automatic logic [7:0] b2_of(entry_t e);
    return e.data[7:0];
  endfunction

endpackage

// File: rtl/wm8960_reg_seq_if.sv
// I2C write-request bundle between the sequencer and the I2C master.
interface wm8960_reg_seq_if;

  logic       Wr_Req;
  logic [7:0] Wr_Dev;
  logic [7:0] Wr_B1;
  logic [7:0] Wr_B2;
  logic       Wr_Done;
  logic       Wr_Err;

  modport master (
    output Wr_Req,
    output Wr_Dev,
    output Wr_B1,
    output Wr_B2,
    input  Wr_Done,
    input  Wr_Err
  );

  modport slave (
    input  Wr_Req,
    input  Wr_Dev,
    input  Wr_B1,
    input  Wr_B2,
    output Wr_Done,
    output Wr_Err
  );

endinterface

// File: rtl/seq_gap_timer.sv
// Down-counter for inter-write idle gaps: load, count to zero, hold.
module seq_gap_timer (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        load,
  input  logic [15:0] val,
  output logic        zero
);

  logic [15:0] cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (cnt != 16'd0) begin
      cnt <= cnt - 16'd1;
    end
  end

  assign zero = (cnt == 16'd0);

endmodule

// File: rtl/wm8960_reg_seq.sv
// WM8960 init sequencer: walks a register table over I2C, then serves
// runtime register writes with retry and inter-write gap handling.
module wm8960_reg_seq
  import wm8960_pkg::*;
#(
  parameter int TAB_LEN   = 32,
  parameter int GAP_CYC   = 100,
  parameter int RST_WAIT  = 50000,
  parameter int RETRY_MAX = 3
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Go,
  output logic [5:0]            Tab_Addr,
  input  logic [15:0]           Tab_Data,
  wm8960_reg_seq_if.master      wr,
  input  logic                  Usr_Req,
  input  logic [6:0]            Usr_Reg,
  input  logic [8:0]            Usr_Dat,
  output logic                  Usr_Ack,
  output logic                  Usr_Err,
  output logic                  Init_Done,
  output logic                  Init_Err,
  output logic                  Busy
);

  localparam logic [15:0] GAP16 = 16'(GAP_CYC);
  localparam logic [15:0] RST16 = 16'(RST_WAIT);
  localparam logic [7:0]  RMAX  = 8'(RETRY_MAX);
  localparam logic [5:0]  LAST  = 6'(TAB_LEN - 1);

  state_t      state;
  logic [5:0]  idx;
  logic [7:0]  retries;
  logic        usr;
  logic        ok;
  logic        xfer;
  logic        gap_load;
  logic [15:0] gap_val;
  logic        gap_zero;

  assign wr.Wr_Dev = DEV_ADDR;

  assign xfer = (state == ISSUE) || (state == WAIT) ||
                (state == U_ISSUE) || (state == U_WAIT);

  assign gap_load = xfer && (wr.Wr_Done || wr.Wr_Err);

  // Only an acknowledged write to the reset register earns the long wait
  assign gap_val = (wr.Wr_Done && wr.Wr_B1[7:1] == RESET_REG) ?
                   RST16 : GAP16;

  seq_gap_timer u_gap (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .load  (gap_load),
    .val   (gap_val),
    .zero  (gap_zero)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      retries   <= '0;
      usr       <= 1'b0;
      ok        <= 1'b0;
      Tab_Addr  <= '0;
      wr.Wr_Req <= 1'b0;
      wr.Wr_B1  <= '0;
      wr.Wr_B2  <= '0;
      Usr_Ack   <= 1'b0;
      Usr_Err   <= 1'b0;
      Init_Done <= 1'b0;
      Init_Err  <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      Usr_Ack <= 1'b0;
      Usr_Err <= 1'b0;
      unique case (state)
        IDLE, RUN, ERR: begin
          if (Go) begin
            idx       <= '0;
            retries   <= '0;
            usr       <= 1'b0;
            Tab_Addr  <= '0;
            Init_Done <= 1'b0;
            Init_Err  <= 1'b0;
            Busy      <= 1'b1;
            state     <= FETCH;
          end else if (state == RUN && Usr_Req && !Usr_Ack) begin
            // Usr_Ack guard: requester still holds Usr_Req on the ack cycle
            usr       <= 1'b1;
            retries   <= '0;
            wr.Wr_B1  <= b1_of({Usr_Reg, Usr_Dat});
            wr.Wr_B2  <= b2_of({Usr_Reg, Usr_Dat});
            wr.Wr_Req <= 1'b1;
            Busy      <= 1'b1;
            state     <= U_ISSUE;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          if (Tab_Data == END_MARK) begin
            Init_Done <= 1'b1;
            Busy      <= 1'b0;
            state     <= RUN;
          end else begin
            wr.Wr_B1  <= b1_of(Tab_Data);
            wr.Wr_B2  <= b2_of(Tab_Data);
            wr.Wr_Req <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE, WAIT, U_ISSUE, U_WAIT: begin
          if (wr.Wr_Done) begin
            wr.Wr_Req <= 1'b0;
            retries   <= '0;
            ok        <= 1'b1;
            state     <= GAP;
          end else if (wr.Wr_Err) begin
            wr.Wr_Req <= 1'b0;
            if (retries < RMAX) begin
              retries <= retries + 8'd1;
              ok      <= 1'b0;
              state   <= GAP;
            end else begin
              retries <= '0;
              Busy    <= 1'b0;
              if (usr) begin
                Usr_Ack <= 1'b1;
                Usr_Err <= 1'b1;
                state   <= RUN;
              end else begin
                Init_Err <= 1'b1;
                state    <= ERR;
              end
            end
          end else begin
            state <= usr ? U_WAIT : WAIT;
          end
        end
        GAP: begin
          if (gap_zero) begin
            if (!ok) begin
              wr.Wr_Req <= 1'b1;
              state     <= usr ? U_ISSUE : ISSUE;
            end else if (usr) begin
              Usr_Ack <= 1'b1;
              Busy    <= 1'b0;
              state   <= RUN;
            end else if (idx == LAST) begin
              Init_Done <= 1'b1;
              Busy      <= 1'b0;
              state     <= RUN;
            end else begin
              idx      <= idx + 6'd1;
              Tab_Addr <= idx + 6'd1;
              state    <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wm8960_reg_seq.sv
// Directed bench for wm8960_reg_seq: ROM and I2C slave models, write scoreboard.
module tb_wm8960_reg_seq;

  logic        Clk;
  logic        Rst_n;
  logic        Go;
  logic [5:0]  Tab_Addr;
  logic [15:0] Tab_Data;
  logic        Usr_Req;
  logic [6:0]  Usr_Reg;
  logic [8:0]  Usr_Dat;
  logic        Usr_Ack;
  logic        Usr_Err;
  logic        Init_Done;
  logic        Init_Err;
  logic        Busy;

  wm8960_reg_seq_if w();

  wm8960_reg_seq #(
    .TAB_LEN   (3),
    .GAP_CYC   (4),
    .RST_WAIT  (200),
    .RETRY_MAX (3)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Go        (Go),
    .Tab_Addr  (Tab_Addr),
    .Tab_Data  (Tab_Data),
    .wr        (w),
    .Usr_Req   (Usr_Req),
    .Usr_Reg   (Usr_Reg),
    .Usr_Dat   (Usr_Dat),
    .Usr_Ack   (Usr_Ack),
    .Usr_Err   (Usr_Err),
    .Init_Done (Init_Done),
    .Init_Err  (Init_Err),
    .Busy      (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [15:0] rom [64];

  always @(posedge Clk) Tab_Data <= rom[Tab_Addr];

  // I2C slave: answers each request 20 cycles after it rises
  int nack_lo;
  int nack_hi;
  int att;
  int rcnt;
  logic pend;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      att       <= 0;
      rcnt      <= 0;
      pend      <= 1'b0;
      w.Wr_Done <= 1'b0;
      w.Wr_Err  <= 1'b0;
    end else begin
      w.Wr_Done <= 1'b0;
      w.Wr_Err  <= 1'b0;
      if (w.Wr_Req && !pend) begin
        if (rcnt == 19) begin
          rcnt <= 0;
          pend <= 1'b1;
          att  <= att + 1;
          if (att >= nack_lo && att < nack_hi) w.Wr_Err <= 1'b1;
          else w.Wr_Done <= 1'b1;
        end else begin
          rcnt <= rcnt + 1;
        end
      end else if (!w.Wr_Req) begin
        pend <= 1'b0;
      end
    end
  end

  int checks;
  int errors;
  logic [15:0] exp_q [$];
  int gaps [$];
  int low_cnt;
  int acks;
  logic prev_req;
  logic [15:0] last_b;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [15:0] e;
    @(negedge Clk);
    if (w.Wr_Req && !prev_req) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      chk("wr_bytes", {w.Wr_B1, w.Wr_B2}, e);
      chk("wr_dev", w.Wr_Dev, 8'h34);
      gaps.push_back(low_cnt);
      last_b = {w.Wr_B1, w.Wr_B2};
    end else if (w.Wr_Req) begin
      chk("wr_stable", {w.Wr_B1, w.Wr_B2}, last_b);
    end
    low_cnt = w.Wr_Req ? 0 : low_cnt + 1;
    prev_req = w.Wr_Req;
    if (Usr_Ack) begin
      acks++;
      chk("usr_err", Usr_Err, 1'b0);
      Usr_Req = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (!Init_Done && !Init_Err && n < 5000) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, n < 5000, 1'b1);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    nack_lo = 0;
    nack_hi = 0;
    gaps.delete();
    low_cnt = 0;
    acks = 0;
    step();
  endtask

  task automatic pulse_go();
    Go = 1'b1;
    step();
    Go = 1'b0;
  endtask

  task automatic push_tab();
    exp_q.push_back(16'h1E00);
    exp_q.push_back(16'h32C0);
    exp_q.push_back(16'h35F8);
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    Rst_n = 1'b0;
    Go = 1'b0;
    Usr_Req = 1'b0;
    Usr_Reg = '0;
    Usr_Dat = '0;
    nack_lo = 0;
    nack_hi = 0;
    low_cnt = 0;
    acks = 0;
    prev_req = 1'b0;
    last_b = '0;
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
    rom[0] = {7'h0F, 9'h000};
    rom[1] = {7'h19, 9'h0C0};
    rom[2] = {7'h1A, 9'h1F8};
    repeat (3) @(negedge Clk);
    chk("rst_req", w.Wr_Req, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_addr", Tab_Addr, 6'd0);
    chk("rst_b1b2", {w.Wr_B1, w.Wr_B2}, 16'h0000);
    chk("rst_done", {Init_Done, Init_Err, Usr_Ack, Usr_Err}, 4'b0);
    chk("rst_dev", w.Wr_Dev, 8'h34);

    // 1: plain table walk
    do_reset();
    push_tab();
    pulse_go();
    chk("s1_busy", Busy, 1'b1);
    wait_end("s1");
    chk("s1_done", Init_Done, 1'b1);
    chk("s1_err", Init_Err, 1'b0);
    chk("s1_left", exp_q.size(), 0);
    chk("s1_ngaps", gaps.size(), 3);
    chk("s1_rst_gap", gaps[1] >= 200 && gaps[1] <= 206, 1'b1);
    chk("s1_gap", gaps[2] >= 4 && gaps[2] <= 10, 1'b1);
    run(2);
    chk("s1_idle", Busy, 1'b0);

    // 2: two NACKs then ACK on entry 1
    do_reset();
    nack_lo = 1;
    nack_hi = 3;
    exp_q.push_back(16'h1E00);
    repeat (3) exp_q.push_back(16'h32C0);
    exp_q.push_back(16'h35F8);
    pulse_go();
    wait_end("s2");
    chk("s2_done", {Init_Done, Init_Err}, 2'b10);
    chk("s2_left", exp_q.size(), 0);

    // 3: retries exhausted on entry 1, then restart
    do_reset();
    nack_lo = 1;
    nack_hi = 5;
    exp_q.push_back(16'h1E00);
    repeat (4) exp_q.push_back(16'h32C0);
    pulse_go();
    wait_end("s3");
    run(2);
    chk("s3_err", {Init_Done, Init_Err}, 2'b01);
    chk("s3_busy", Busy, 1'b0);
    chk("s3_req", w.Wr_Req, 1'b0);
    chk("s3_addr", Tab_Addr, 6'd1);
    chk("s3_left", exp_q.size(), 0);
    push_tab();
    pulse_go();
    chk("s3_go_addr", Tab_Addr, 6'd0);
    chk("s3_go_flags", {Busy, Init_Err}, 2'b10);
    wait_end("s3b");
    chk("s3_done", Init_Done, 1'b1);
    chk("s3b_left", exp_q.size(), 0);

    // 4: end marker at entry 1
    do_reset();
    rom[1] = 16'hFFFF;
    exp_q.push_back(16'h1E00);
    pulse_go();
    wait_end("s4");
    run(50);
    chk("s4_done", Init_Done, 1'b1);
    chk("s4_busy", Busy, 1'b0);
    chk("s4_left", exp_q.size(), 0);
    rom[1] = {7'h19, 9'h0C0};

    // 5: runtime request held off until init completes
    do_reset();
    push_tab();
    exp_q.push_back(16'h0579);
    pulse_go();
    Usr_Reg = 7'h02;
    Usr_Dat = 9'h179;
    Usr_Req = 1'b1;
    wait_end("s5");
    chk("s5_no_early_ack", acks, 0);
    n = 0;
    while (acks == 0 && n < 2000) begin
      step();
      n++;
    end
    chk("s5_ack_timeout", n < 2000, 1'b1);
    run(30);
    chk("s5_acks", acks, 1);
    chk("s5_left", exp_q.size(), 0);
    chk("s5_idle", {Busy, Init_Done}, 2'b01);

    // 6: reset in the middle of a write
    do_reset();
    exp_q.push_back(16'h1E00);
    pulse_go();
    n = 0;
    while (!w.Wr_Req && n < 100) begin
      step();
      n++;
    end
    chk("s6_req_timeout", n < 100, 1'b1);
    run(5);
    chk("s6_req_hi", w.Wr_Req, 1'b1);
    Rst_n = 1'b0;
    #1;
    chk("s6_req", w.Wr_Req, 1'b0);
    chk("s6_outs", {Tab_Addr, w.Wr_B1, w.Wr_B2}, 22'd0);
    chk("s6_flags", {Busy, Init_Done, Init_Err, Usr_Ack, Usr_Err}, 5'd0);
    chk("s6_dev", w.Wr_Dev, 8'h34);
    @(negedge Clk);
    Rst_n = 1'b1;
    run(40);
    chk("s6_idle", {w.Wr_Req, Busy}, 2'b00);
    chk("s6_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wm8960_reg_seq.md
WM8960_REG_SEQ -- requirements
Module: wm8960_reg_seq

Interface
REQ-001 Parameter TAB_LEN, default 32, number of register-table entries (1..64).
REQ-002 Parameter GAP_CYC, default 100, idle Clk cycles after each successful write.
REQ-003 Parameter RST_WAIT, default 50000, idle Clk cycles after a successful write to the codec reset register; this replaces GAP_CYC.
REQ-004 Parameter RETRY_MAX, default 3, retries per write after a NACK.
REQ-005 Clk  in  1  system clock; all logic on posedge Clk.
REQ-006 Rst_n  in  1  reset, asynchronous, active-low.
REQ-007 Go  in  1  single-cycle start pulse for the init sequence.
REQ-008 Tab_Addr  out  6  table-ROM address.
REQ-009 Tab_Data  in  16  table entry {reg[6:0], data[8:0]}; valid one cycle after Tab_Addr.
REQ-010 Wr_Req  out  1  I2C write request, level signal.
REQ-011 Wr_Dev  out  8  device write address; constant 8'h34.
REQ-012 Wr_B1  out  8  first payload byte {reg[6:0], data[8]}.
REQ-013 Wr_B2  out  8  second payload byte data[7:0].
REQ-014 Wr_Done  in  1  one-cycle pulse: write ACKed and complete.
REQ-015 Wr_Err  in  1  one-cycle pulse: write NACKed; never coincident with Wr_Done.
REQ-016 Usr_Req  in  1  runtime write request; the requester holds it until Usr_Ack.
REQ-017 Usr_Reg  in  7  runtime register address; Usr_Dat  in  9  runtime register data.
REQ-018 Usr_Ack  out  1  one-cycle pulse: runtime write finished.
REQ-019 Usr_Err  out  1  valid with Usr_Ack: the runtime write failed.
REQ-020 Init_Done  out  1  table fully written; stays high until reset or Go.
REQ-021 Init_Err  out  1  init aborted after exhausting retries.
REQ-022 Busy  out  1  sequence or transaction in progress.

Function
REQ-023 States: IDLE, FETCH, LATCH, ISSUE, WAIT, GAP, RUN, U_ISSUE, U_WAIT, ERR.
REQ-024 Go in IDLE, RUN or ERR: clear index, retries, Init_Done and Init_Err; enter FETCH. Go is ignored in all other states.
REQ-025 FETCH drives Tab_Addr = index for one cycle. LATCH captures Tab_Data into the shadow registers on the next cycle.
REQ-026 An entry equal to 16'hFFFF is an end marker: LATCH goes directly to RUN with Init_Done=1.
REQ-027 ISSUE/WAIT handshake:
- Wr_Req is asserted on entry to ISSUE.
- Wr_B1 and Wr_B2 are stable while Wr_Req=1.
- Wr_Req deasserts on the cycle after Wr_Done or Wr_Err is sampled.
REQ-028 On Wr_Done:
- Load the gap counter with RST_WAIT if the entry's reg==7'h0F, otherwise GAP_CYC.
- Reset the retry count to 0.
- Enter GAP.
REQ-029 On Wr_Err with retries<RETRY_MAX: increment retries, load GAP_CYC, enter GAP, then reissue the same entry.
REQ-030 On Wr_Err with retries==RETRY_MAX: enter ERR with Init_Err=1.
REQ-031 GAP counter reaching 0 after a success:
- If index==TAB_LEN-1, enter RUN with Init_Done=1.
- Otherwise increment index and enter FETCH.
REQ-032 RUN with Usr_Req=1: latch Usr_Reg/Usr_Dat and enter U_ISSUE, using the same handshake, retry and gap rules.
REQ-033 Runtime completion: pulse Usr_Ack one cycle after the GAP following success, with Usr_Err=0; return to RUN.
REQ-034 Runtime final failure: pulse Usr_Ack with Usr_Err=1; return to RUN, not ERR.
REQ-035 Usr_Req outside RUN is not acknowledged and stays pending. Go and Usr_Req together in RUN: Go wins.
REQ-036 Busy=0 only in IDLE, RUN and ERR.
REQ-037 The gap counter is 16 bits. GAP_CYC=0 gives a one-cycle GAP state.

Reset
REQ-038 Rst_n low clears asynchronously:
- state=IDLE, index=0, retries=0.
- Tab_Addr, Wr_Req, Wr_B1, Wr_B2, Usr_Ack, Usr_Err, Init_Done, Init_Err and Busy = 0.
- Wr_Dev stays 8'h34.
REQ-039 Reset mid-transaction drops Wr_Req immediately. Wr_Done or Wr_Err arriving after reset release is ignored in IDLE.

Structure
REQ-040 Shared package wm8960_pkg holds:
- DEV_ADDR 8'h34, RESET_REG 7'h0F, END_MARK 16'hFFFF;
- the state enum;
- the entry typedef {reg[6:0], data[8:0]}.
REQ-041 The gap counter is the single sub-module seq_gap_timer: load, count-down and zero flag.

Verification
REQ-042 Scenario 1: TAB_LEN=3, table {0x0F:0x000, 0x19:0x0C0, 0x1A:0x1F8}, Go, model acks every write after 20 cycles.
- 3 writes with Wr_B1/Wr_B2 = 1E/00, 32/C0, 35/F8.
- RST_WAIT gap after the first write.
- Init_Done=1.
REQ-043 Scenario 2: NACK twice then ACK on entry 1 -> 3 writes of the identical entry, then the sequence continues.
REQ-044 Scenario 3: NACK 4 times with RETRY_MAX=3 -> Init_Err=1, Busy=0, Wr_Req=0. Go then restarts at Tab_Addr=0.
REQ-045 Scenario 4: END_MARK at entry 1 -> exactly 1 write, then Init_Done=1.
REQ-046 Scenario 5: Usr_Req during init is held until RUN, then writes Usr_Reg=0x02/Usr_Dat=0x179 as B1=05, B2=79, and Usr_Ack pulses once.
REQ-047 Scenario 6: Rst_n low during WAIT -> Wr_Req=0 in the same cycle and all outputs at reset values.
